video_in_dma: RTL
=================

Name: video_in_dma

Overview:
- Wishbone master stage directly downstream of the video input FIFO.
- Pops 32-bit pixel packs (4 pixels per word) from the show-ahead FIFO and writes them to a RAM frame buffer in fixed-length locked bursts.
- Ping-pongs between two frame buffer base addresses.
- Raises a one-cycle processor interrupt at each completed frame.

Parameters:
- WORDS_PER_FRAME, 76800: 32-bit words per frame (640x480 pixels / 4).
- BURST_LEN, 8: words per Wishbone burst. Power of two, at most 16; WORDS_PER_FRAME is a multiple of it.
- CNT_W, 5: width of the FIFO occupancy input.

Ports:
- clk  in  1  single system clock.
- nRST  in  1  reset; synchronous and active-high despite the name.
- cfg_enable  in  1  from slave registers; 1 = capture allowed.
- cfg_base0  in  32  byte address of frame buffer 0; word aligned.
- cfg_base1  in  32  byte address of frame buffer 1; word aligned.
- nb_pack_available  in  CNT_W  FIFO occupancy in words.
- data_fifo  in  32  FIFO head word; valid whenever occupancy > 0.
- r_ack  out  1  pop strobe: removes the head word this cycle.
- p_wb_STB_O  out  1  Wishbone strobe.
- p_wb_CYC_O  out  1  Wishbone cycle.
- p_wb_LOCK_O  out  1  Wishbone lock.
- p_wb_WE_O  out  1  Wishbone write enable.
- p_wb_SEL_O  out  4  Wishbone byte select.
- p_wb_ADR_O  out  32  Wishbone byte address.
- p_wb_DAT_O  out  32  Wishbone write data.
- p_wb_ACK_I  in  1  Wishbone acknowledge.
- p_wb_ERR_I  in  1  Wishbone error.
- interrupt  out  1  one-cycle pulse per completed frame.
- cur_buf  out  1  index of the buffer most recently completed.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: all Wishbone outputs 0, ADR 0, DAT 0, r_ack 0, interrupt 0, cur_buf 1. State IDLE, word counter 0, write buffer index 0.
- State IDLE:
  - Stay while cfg_enable=0.
  - On cfg_enable=1, latch the base of the current write buffer into the address register and clear the word counter -> WAIT.
- State WAIT:
  - If cfg_enable=0 and word counter = 0 -> IDLE.
  - Else if nb_pack_available >= BURST_LEN -> BURST.
  - cfg_enable=0 mid-frame has no effect; the frame always completes.
- State BURST:
  - CYC=LOCK=STB=WE=1, SEL=4'hF, DAT=data_fifo, ADR=address register.
  - On ACK_I: r_ack=1 in the same cycle (combinational from ACK_I in BURST); address += 4; word counter += 1; beat counter += 1.
  - No ACK: hold all outputs and the same head word. No pop without ACK.
  - After the BURST_LEN-th ACK: drop CYC/STB/LOCK the next cycle -> WAIT, or -> DONE if word counter = WORDS_PER_FRAME.
  - Bus is released between bursts: one idle cycle minimum.
- State DONE (one cycle):
  - interrupt=1; cur_buf = write buffer index; toggle write buffer index.
  - Load address from the new buffer's base; word counter 0.
  - -> WAIT if cfg_enable=1, else -> IDLE.
- ERR_I in BURST (macro absent):
  - Treat as ACK: pop the word, advance address. Data is lost, frame length preserved.
  - ACK and ERR together count as one ACK.
- FIFO conditions:
  - Occupancy below BURST_LEN: wait, no partial bursts.
  - FIFO empty is never popped, since a burst starts only when BURST_LEN words are present.
- Base changes: cfg_base0/1 are sampled only at frame start (IDLE exit or DONE). Changes mid-frame take effect next frame.
- Reset mid-burst: outputs drop the next edge; the partially written frame is abandoned with no interrupt.
- Address arithmetic: 32-bit wrap-around, no saturation.
- Word counter: width clog2(WORDS_PER_FRAME+1).

Optional Feature:
- Macro VIDEO_IN_DMA_ERR_RETRY_EN.
- Defined:
  - On ERR_I (without ACK_I), the beat is not popped and the address is not advanced.
  - Re-issue after deasserting STB for one cycle, keeping CYC and LOCK high.
  - Up to 3 retries per beat. On the 4th ERR, fall back to ACK-like skip behaviour.
  - Retry counter resets on each successful ACK.
- Undefined: skip behaviour only. No retry counter is instantiated.

Test Plan:
- Reset with cfg_enable=1 and occupancy 8 -> first cycle after reset release shows CYC=0 and interrupt=0. Second cycle: CYC=STB=LOCK=WE=1, SEL=4'hF, ADR=cfg_base0.
- WORDS_PER_FRAME=16, base0=0x1000, base1=0x2000, FIFO fed words 0..31, ACK every cycle:
  - First 16 writes land at 0x1000..0x103C with data 0..15.
  - interrupt pulses once with cur_buf=0.
  - Next 16 writes land at 0x2000.. with data 16..31; interrupt pulses with cur_buf=1.
- Occupancy held at 7 -> no CYC for 100 cycles. Raise to 8 -> burst starts within 2 cycles.
- Slave inserts 3 wait states per beat -> r_ack pulses exactly on ACK cycles; DAT and ADR stable through the waits; exactly 8 pops per burst.
- ERR_I on beat 3 of the first burst:
  - Macro undefined: ADR advances and 8 pops occur.
  - Macro defined: same ADR re-issued after a 1-cycle STB gap; data is written on the subsequent ACK.
- cfg_enable dropped mid-frame -> frame completes, interrupt fires, then IDLE with CYC=0 while the FIFO still holds >= 8 words.

Source files
------------

// File: rtl/video_in_dma.sv
// Wishbone burst-write DMA from the video input FIFO into ping-pong frame buffers.
// Optional ERR_I retry per beat is enabled by defining VIDEO_IN_DMA_ERR_RETRY_EN.
module video_in_dma #(
    parameter int WORDS_PER_FRAME = 76800,
    parameter int BURST_LEN       = 8,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             cfg_enable,
    input  logic [31:0]      cfg_base0,
    input  logic [31:0]      cfg_base1,
    input  logic [CNT_W-1:0] nb_pack_available,
    input  logic [31:0]      data_fifo,
    output logic             r_ack,
    output logic             p_wb_STB_O,
    output logic             p_wb_CYC_O,
    output logic             p_wb_LOCK_O,
    output logic             p_wb_WE_O,
    output logic [3:0]       p_wb_SEL_O,
    output logic [31:0]      p_wb_ADR_O,
    output logic [31:0]      p_wb_DAT_O,
    input  logic             p_wb_ACK_I,
    input  logic             p_wb_ERR_I,
    output logic             interrupt,
    output logic             cur_buf
);

    localparam int WCNT_W = $clog2(WORDS_PER_FRAME + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  BURST_OCC = CNT_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_BURST = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [31:0]         addr_r;
    logic [WCNT_W-1:0]   word_cnt_r;
    logic [BEAT_W-1:0]   beat_cnt_r;
    logic                wbuf_r;
    logic                cur_buf_r;
    logic                interrupt_r;
    logic                beat_s;
    logic                retry_s;
    logic                last_beat_s;
    logic                frame_end_s;
    logic                bus_s;

    function automatic logic [31:0] sel_base(input logic idx, input logic [31:0] b0,
                                             input logic [31:0] b1);
        return idx ? b1 : b0;
    endfunction

`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
    logic [1:0] retry_cnt_r;

    // Retry budget per beat: cleared by any completed beat, bumped by each retried ERR.
    always_ff @(posedge clk) begin
        if (nRST) begin
            retry_cnt_r <= 2'd0;
        end else if (state_r == S_BURST) begin
            if (beat_s) begin
                retry_cnt_r <= 2'd0;
            end else if (retry_s) begin
                retry_cnt_r <= retry_cnt_r + 2'd1;
            end else begin
                retry_cnt_r <= retry_cnt_r;
            end
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end
`endif

    // Beat completion decode; ERR either completes the beat (data lost) or asks for a retry.
    always_comb begin
        beat_s  = 1'b0;
        retry_s = 1'b0;
        if (state_r == S_BURST) begin
            if (p_wb_ACK_I) begin
                beat_s = 1'b1;
            end else if (p_wb_ERR_I) begin
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
                if (retry_cnt_r == 2'd3) begin
                    beat_s = 1'b1;
                end else begin
                    retry_s = 1'b1;
                end
`else
                beat_s = 1'b1;
`endif
            end else begin
                beat_s = 1'b0;
            end
        end else begin
            beat_s = 1'b0;
        end
        last_beat_s = beat_s && (beat_cnt_r == LAST_BEAT);
        frame_end_s = last_beat_s && (word_cnt_r == LAST_WORD);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_enable) state_nxt_s = S_WAIT;
                else            state_nxt_s = S_IDLE;
            end
            S_WAIT: begin
                // A started frame always runs to completion, even with capture disabled.
                if (!cfg_enable && (word_cnt_r == {WCNT_W{1'b0}})) state_nxt_s = S_IDLE;
                else if (nb_pack_available >= BURST_OCC)            state_nxt_s = S_BURST;
                else                                                state_nxt_s = S_WAIT;
            end
            S_BURST: begin
                if (last_beat_s)  state_nxt_s = frame_end_s ? S_DONE : S_WAIT;
                else if (retry_s) state_nxt_s = S_GAP;
                else              state_nxt_s = S_BURST;
            end
            S_GAP: begin
                state_nxt_s = S_BURST;
            end
            S_DONE: begin
                if (cfg_enable) state_nxt_s = S_WAIT;
                else            state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, address/counters, buffer ping-pong and interrupt registers.
    always_ff @(posedge clk) begin
        if (nRST) begin
            state_r     <= S_IDLE;
            addr_r      <= 32'h0000_0000;
            word_cnt_r  <= {WCNT_W{1'b0}};
            beat_cnt_r  <= {BEAT_W{1'b0}};
            wbuf_r      <= 1'b0;
            cur_buf_r   <= 1'b1;
            interrupt_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            interrupt_r <= frame_end_s;
            case (state_r)
                S_IDLE: begin
                    if (cfg_enable) begin
                        addr_r     <= sel_base(wbuf_r, cfg_base0, cfg_base1);
                        word_cnt_r <= {WCNT_W{1'b0}};
                        beat_cnt_r <= {BEAT_W{1'b0}};
                    end
                end
                S_BURST: begin
                    if (beat_s) begin
                        addr_r     <= addr_r + 32'd4;
                        word_cnt_r <= word_cnt_r + WCNT_W'(1);
                        beat_cnt_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_cnt_r + BEAT_W'(1);
                    end
                    // cur_buf is updated together with the interrupt pulse so both are seen at once.
                    if (frame_end_s) cur_buf_r <= wbuf_r;
                end
                S_DONE: begin
                    wbuf_r     <= ~wbuf_r;
                    addr_r     <= sel_base(~wbuf_r, cfg_base0, cfg_base1);
                    word_cnt_r <= {WCNT_W{1'b0}};
                    beat_cnt_r <= {BEAT_W{1'b0}};
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    assign bus_s       = (state_r == S_BURST) || (state_r == S_GAP);
    assign p_wb_CYC_O  = bus_s;
    assign p_wb_LOCK_O = bus_s;
    assign p_wb_WE_O   = bus_s;
    assign p_wb_STB_O  = (state_r == S_BURST);
    assign p_wb_SEL_O  = bus_s ? 4'hF : 4'h0;
    assign p_wb_ADR_O  = addr_r;
    assign p_wb_DAT_O  = bus_s ? data_fifo : 32'h0000_0000;
    assign r_ack       = beat_s;
    assign interrupt   = interrupt_r;
    assign cur_buf     = cur_buf_r;

endmodule
